// File: rtl/load_cell_a2d.sv
// load_cell_a2d: round-robin A2D front end for an ADC128S-style SPI converter.
//
// Each nxt strobe converts the next channel in the rotation (ch0, ch4, ch5, ch6) with two
// back-to-back SPI transactions. The first returns stale data from the previous channel and
// is discarded. The low 12 bits of the second land in the matching result register.
//
// Ports:
//   clk        system clock (50 MHz); SCLK = clk/32
//   rst_n      synchronous active-low reset
//   nxt        one-cycle request to convert the next channel (ignored while busy)
//   MISO       serial data from the ADC
//   SS_n       active-low slave select
//   SCLK       serial clock, idles high
//   MOSI       serial command, MSB first
//   lft_ld     ch0 result
//   rght_ld    ch4 result
//   steer_pot  ch5 result
//   batt       ch6 result
//   cnv_cmplt  one-cycle pulse when a result register updates
//   busy       high from acceptance of nxt until cnv_cmplt
module load_cell_a2d (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StTrn1, StGap, StTrn2, StDone} state_e;

  // The divider rests at DivIdle, so the first cycle of SS_n low already sees DivIdle + 1.
  // That places the first SCLK fall 8 clks after SS_n falls.
  localparam logic [4:0] DivIdle = 5'b10111;
  localparam logic [4:0] DivFall = 5'b11111;  // cycle before an SCLK fall: shift TX
  localparam logic [4:0] DivSamp = 5'b10001;  // one clk after an SCLK rise: sample MISO

  state_e      state_q, state_d;
  logic        ss_n_q, ss_n_d;
  logic [4:0]  div_q, div_d;
  logic [4:0]  cnt_q, cnt_d;  // sample count in a transaction, cycle count in GAP
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [1:0]  rr_q, rr_d;
  logic [11:0] lft_q, lft_d, rght_q, rght_d, steer_q, steer_d, batt_q, batt_d;
  logic        cmplt_q, cmplt_d;
  logic        busy_q, busy_d;

  logic [2:0]  ch;
  logic [15:0] cmd;
  logic        trn_end;

  always_comb begin
    case (rr_q)
      2'd0:    ch = 3'd0;
      2'd1:    ch = 3'd4;
      2'd2:    ch = 3'd5;
      default: ch = 3'd6;
    endcase
  end

  assign cmd = {2'b00, ch, 11'h000};

  // Back porch: after the 16th sample, the next would-be fall point ends the transaction.
  assign trn_end = !ss_n_q && (div_q == DivFall) && (cnt_q == 5'd16);

  always_comb begin
    state_d = state_q;
    ss_n_d  = ss_n_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    steer_d = steer_q;
    batt_d  = batt_q;
    cmplt_d = 1'b0;
    busy_d  = busy_q;

    if (!ss_n_q) begin
      if (div_q == DivFall) tx_d = {tx_q[14:0], 1'b0};
      if (div_q == DivSamp) begin
        rx_d  = {rx_q[14:0], MISO};
        cnt_d = cnt_q + 5'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (nxt) begin
          state_d = StTrn1;
          ss_n_d  = 1'b0;
          tx_d    = cmd;
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
        end
      end
      StTrn1: begin
        if (trn_end) begin
          state_d = StGap;
          ss_n_d  = 1'b1;
          cnt_d   = 5'd0;
        end
      end
      StGap: begin
        if (cnt_q == 5'd1) begin
          state_d = StTrn2;
          ss_n_d  = 1'b0;
          tx_d    = cmd;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StTrn2: begin
        if (trn_end) begin
          state_d = StDone;
          ss_n_d  = 1'b1;
        end
      end
      StDone: begin
        case (rr_q)
          2'd0:    lft_d   = rx_q[11:0];
          2'd1:    rght_d  = rx_q[11:0];
          2'd2:    steer_d = rx_q[11:0];
          default: batt_d  = rx_q[11:0];
        endcase
        cmplt_d = 1'b1;
        busy_d  = 1'b0;
        rr_d    = rr_q + 2'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    div_d = ss_n_d ? DivIdle : div_q + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ss_n_q  <= 1'b1;
      div_q   <= DivIdle;
      cnt_q   <= 5'd0;
      tx_q    <= 16'h0000;
      rx_q    <= 16'h0000;
      rr_q    <= 2'd0;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      steer_q <= 12'h000;
      batt_q  <= 12'h000;
      cmplt_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_n_q  <= ss_n_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rr_q    <= rr_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      steer_q <= steer_d;
      batt_q  <= batt_d;
      cmplt_q <= cmplt_d;
      busy_q  <= busy_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = ss_n_q ? 1'b1 : div_q[4];
  assign MOSI      = !ss_n_q && tx_q[15];
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign cnv_cmplt = cmplt_q;
  assign busy      = busy_q;

endmodule
